// File: rtl/net_router_switch_arbiter.sv
// ----------------------------------------------------------------------------
// net_router_switch_arbiter
//
// Output-port scheduler for one router output. Three input streams
// (0 = west/self, 1, 2) share the output through round-robin arbitration.
// The winning message is registered in a single-entry output buffer. This
// gives fair access and a registered timing boundary toward the output
// channel. The buffer can drain and refill in the same cycle, so sustained
// throughput is one message per cycle.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-low reset (0 = reset)
//   istream_msg  per-input message, packed [input][bit]
//   istream_val  per-input valid
//   istream_rdy  per-input ready, at most one bit high per cycle
//   ostream_msg  buffered output message
//   ostream_val  output valid (buffer occupied)
//   ostream_rdy  downstream ready
//   grant_idx    index of the most recently accepted input, held when idle
// ----------------------------------------------------------------------------
module net_router_switch_arbiter #(
    parameter int unsigned p_msg_nbits = 44
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0][p_msg_nbits-1:0] istream_msg,
    input  logic [2:0]                  istream_val,
    output logic [2:0]                  istream_rdy,
    output logic [p_msg_nbits-1:0]      ostream_msg,
    output logic                        ostream_val,
    input  logic                        ostream_rdy,
    output logic [1:0]                  grant_idx
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                   buf_full_q, buf_full_d;
    logic [p_msg_nbits-1:0] buf_msg_q,  buf_msg_d;
    logic [1:0]             ptr_q,      ptr_d;       // highest-priority input, 0..2
    logic [1:0]             grant_idx_q, grant_idx_d;

    // ------------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------------
    logic       gnt_valid;
    logic [1:0] gnt;
    logic [2:0] cand;

    // Scan ptr, ptr+1, ptr+2 (mod 3); the first valid input wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = 2'd0;
        cand      = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, ptr_q} + 3'(i);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!gnt_valid && istream_val[cand[1:0]]) begin
                gnt_valid = 1'b1;
                gnt       = cand[1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    logic can_accept;
    logic fire;
    logic drain;

    // A full buffer can still take a new message when it is draining now.
    assign can_accept = !buf_full_q || ostream_rdy;

    // Readies are forced low while reset is asserted, even though the buffer
    // already reads empty, so no upstream handshake completes during reset.
    always_comb begin
        istream_rdy = 3'b000;
        if (reset && gnt_valid) begin
            istream_rdy[gnt] = can_accept;
        end
    end

    assign fire  = reset && gnt_valid && can_accept;
    assign drain = buf_full_q && ostream_rdy;

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        buf_full_d  = buf_full_q;
        buf_msg_d   = buf_msg_q;
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;

        if (fire) begin
            // Covers both plain fill and simultaneous drain+fill.
            buf_full_d  = 1'b1;
            buf_msg_d   = istream_msg[gnt];
            grant_idx_d = gnt;
            ptr_d       = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
        end else if (drain) begin
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full_q  <= 1'b0;
            buf_msg_q   <= '0;
            ptr_q       <= 2'd1;
            grant_idx_q <= 2'd0;
        end else begin
            buf_full_q  <= buf_full_d;
            buf_msg_q   <= buf_msg_d;
            ptr_q       <= ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ostream_val = buf_full_q;
    assign ostream_msg = buf_msg_q;
    assign grant_idx   = grant_idx_q;

    // ------------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    ptr_legal_a : assert property (@(posedge clk) disable iff (!reset)
        ptr_q != 2'd3);

    rdy_onehot_a : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(istream_rdy));

    rdy_needs_val_a : assert property (@(posedge clk) disable iff (!reset)
        (istream_rdy & ~istream_val) == 3'b000);

    out_hold_a : assert property (@(posedge clk) disable iff (!reset)
        (ostream_val && !ostream_rdy) |=> (ostream_val && $stable(ostream_msg)));
`endif

endmodule

// File: tb/tb_net_router_switch_arbiter.sv
// ----------------------------------------------------------------------------
// tb_net_router_switch_arbiter
//
// Directed scenarios followed by randomized traffic. A transaction-level model
// (buffer flag + message, priority pointer, last grant) predicts ready, output
// and grant values every cycle. Inputs change on the falling edge; outputs are
// sampled 1 time unit after it.
// ----------------------------------------------------------------------------
module tb_net_router_switch_arbiter;

    localparam int unsigned W = 44;

    logic                 clk;
    logic                 reset;
    logic [2:0][W-1:0]    istream_msg;
    logic [2:0]           istream_val;
    logic [2:0]           istream_rdy;
    logic [W-1:0]         ostream_msg;
    logic                 ostream_val;
    logic                 ostream_rdy;
    logic [1:0]           grant_idx;

    net_router_switch_arbiter #(
        .p_msg_nbits (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_msg (istream_msg),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .ostream_msg (ostream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit         m_full;
    logic [W-1:0] m_msg;
    int         m_ptr;
    int         m_gnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_msg  = '0;
        m_ptr  = 1;
        m_gnt  = 0;
    endtask

    function automatic logic [W-1:0] rand_msg();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    // One clock cycle: drive inputs, check pre-edge behaviour against the
    // model, clock, advance the model. Entered and left just after a negedge.
    task automatic step(input logic [2:0] val, input logic [2:0][W-1:0] msgs,
                        input logic ordy);
        int         win;
        bit         can;
        logic [2:0] exp_rdy;
        istream_val = val;
        istream_msg = msgs;
        ostream_rdy = ordy;
        #1;
        win = -1;
        for (int i = 0; i < 3; i++) begin
            int j;
            j = (m_ptr + i) % 3;
            if (win < 0 && val[j]) win = j;
        end
        can     = !m_full || ordy;
        exp_rdy = (win >= 0 && can) ? 3'(1 << win) : 3'b000;
        check("istream_rdy", istream_rdy, exp_rdy);
        check("ostream_val", ostream_val, m_full);
        check("ostream_msg", ostream_msg, m_msg);
        check("grant_idx", grant_idx, m_gnt);
        @(posedge clk);
        if (win >= 0 && can) begin
            m_full = 1'b1;
            m_msg  = msgs[win];
            m_gnt  = win;
            m_ptr  = (win + 1) % 3;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic step_simple(input logic [2:0] val, input logic ordy);
        logic [2:0][W-1:0] msgs;
        for (int i = 0; i < 3; i++) msgs[i] = rand_msg();
        step(val, msgs, ordy);
    endtask

    // Asynchronous reset held for n falling edges, with all inputs requesting.
    task automatic do_reset(input int n);
        reset       = 1'b0;
        istream_val = 3'b111;
        ostream_rdy = 1'b1;
        #1;
        check("rst_oval", ostream_val, 1'b0);
        check("rst_omsg", ostream_msg, '0);
        check("rst_irdy", istream_rdy, 3'b000);
        repeat (n) @(negedge clk);
        check("rst_irdy_hold", istream_rdy, 3'b000);
        reset = 1'b1;
        model_reset();
    endtask

    logic [2:0][W-1:0] dm;
    logic [W-1:0]      held;
    int                exp_order [6] = '{1, 2, 0, 1, 2, 0};

    initial begin
        reset       = 1'b0;
        istream_val = 3'b000;
        istream_msg = '0;
        ostream_rdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("init_oval", ostream_val, 1'b0);
        check("init_gidx", grant_idx, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-transfer discards the buffered message.
        step_simple(3'b001, 1'b0);
        step_simple(3'b110, 1'b0);
        check("t1_full_before", ostream_val, 1'b1);
        do_reset(2);
        #1;
        check("t1_oval_after", ostream_val, 1'b0);
        step_simple(3'b111, 1'b1);
        check("t1_first_grant", grant_idx, 2'd1);

        // Only in0 valid, message 0x0AB, one-cycle latency.
        dm    = '0;
        dm[0] = W'('h0AB);
        step(3'b001, dm, 1'b1);
        check("t2_oval", ostream_val, 1'b1);
        check("t2_omsg", ostream_msg, W'('h0AB));
        check("t2_gidx", grant_idx, 2'd0);

        // All inputs valid: rotation 1,2,0,... one message per cycle.
        for (int k = 0; k < 6; k++) begin
            step_simple(3'b111, 1'b1);
            check("t3_order", grant_idx, 64'(exp_order[k]));
            check("t3_oval", ostream_val, 1'b1);
        end

        // Stall with a full buffer, then drain and refill with no bubble.
        held = m_msg;
        for (int k = 0; k < 4; k++) begin
            step_simple(3'b111, 1'b0);
            check("t4_stall_msg", ostream_msg, held);
        end
        step_simple(3'b111, 1'b1);
        check("t4_no_bubble_val", ostream_val, 1'b1);
        check("t4_no_bubble_gidx", grant_idx, 2'd1);

        // Pointer moves only on accept.
        do_reset(1);
        step_simple(3'b000, 1'b1);
        step_simple(3'b100, 1'b1);
        check("t5_g2", grant_idx, 2'd2);
        step_simple(3'b110, 1'b1);
        check("t5_g1", grant_idx, 2'd1);
        step_simple(3'b110, 1'b1);
        check("t5_g2_next", grant_idx, 2'd2);

        // Idle gap after granting in1 leaves the pointer at 2.
        step_simple(3'b010, 1'b1);
        check("t6_g1", grant_idx, 2'd1);
        for (int k = 0; k < 5; k++) step_simple(3'b000, 1'b1);
        check("t6_idle_gidx", grant_idx, 2'd1);
        check("t6_idle_oval", ostream_val, 1'b0);
        step_simple(3'b101, 1'b1);
        check("t6_g2", grant_idx, 2'd2);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset(1 + int'($urandom_range(0, 2)));
            end else begin
                step_simple(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
